crc_frame_gen: RTL

CRC_FRAME_GEN -- requirements
Module: crc_frame_gen

---
 rtl/crc_frame_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/crc_frame_gen.sv
// Appends a reflected CRC-32 beat to each AXI-Stream frame, behind a single output register stage.
// Optional build macro CRC_ERR_INJECT_EN adds err_inject, which flips bit 0 of the CRC beat.
module crc_frame_gen #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           frame_count_out,
`ifdef CRC_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic                  busy
);

    localparam logic [31:0] CrcInit     = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPolyRefl = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCrc
    } state_e;

    state_e      state_q;
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [31:0] crc_beat;
    logic        out_free;
    logic        s_hs;

    // Reflected CRC: bit 0 of byte 0 enters first, which is LSB-first over the whole word.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CrcPolyRefl;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign crc_next = crc32_word(crc_q, s_axis_tdata);

    // Reset term keeps tready low the instant reset is asserted, not only after an edge.
    assign s_axis_tready = !axis_areset && enable && (state_q != StCrc) && out_free;
    assign s_hs          = s_axis_tvalid && s_axis_tready;

`ifdef CRC_ERR_INJECT_EN
    assign crc_beat = ~crc_q ^ {31'd0, err_inject};
`else
    assign crc_beat = ~crc_q;
`endif

    assign busy = (state_q != StIdle) || (m_axis_tvalid && m_axis_tlast);

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q         <= StIdle;
            crc_q           <= CrcInit;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            frame_count_out <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frame_count_out <= frame_count_out + 32'd1;
            end

            unique case (state_q)
                StIdle, StData: begin
                    if (s_hs) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        crc_q         <= crc_next;
                        state_q       <= s_axis_tlast ? StCrc : StData;
                    end else if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                StCrc: begin
                    // Input is blocked here, so the register only ever drains or takes the CRC.
                    if (out_free) begin
                        m_axis_tdata  <= crc_beat;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        crc_q         <= CrcInit;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
